// File: rtl/debug_scanner_pkg.sv
// Shared definitions for the debug bus between the scanner and the game's debug responder.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: command codes, debug-bus field layout, scanner state and phase enums.
package debug_scanner_pkg;

  // Command codes on bus_out[1:0]; the responder decodes the same values.
  typedef enum logic [1:0] {
    CMD_IDLE             = 2'd0,
    CMD_READ_BOARD       = 2'd1,
    CMD_READ_CURRENT_COL = 2'd2,
    CMD_READ_WINNER      = 2'd3
  } dbg_cmd_e;

  // Debug bus layout: [7:5] row, [4:2] col, [1:0] cmd.
  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    dbg_cmd_e   cmd;
  } dbg_bus_t;

  // Responder must enable every driven data bit, bus_oe_in[7:2].
  localparam logic [5:0] OE_DATA_ALL = 6'h3F;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    PRESENT,
    RELEASE
  } scan_state_e;

  // Which part of the scan the next command belongs to.
  typedef enum logic [1:0] {
    PH_BOARD,
    PH_COL,
    PH_WIN,
    PH_END
  } scan_phase_e;

  function automatic logic [7:0] pack_bus(input dbg_cmd_e cmd, input logic [2:0] row,
                                          input logic [2:0] col);
    dbg_bus_t b;
    b.cmd = cmd;
    b.row = row;
    b.col = col;
    return b;
  endfunction

endpackage

// File: rtl/debug_scanner_if.sv
// Bundles the responder-facing debug bus and the record stream of the debug scanner.
// Latency: n/a (wiring only).
// Backpressure: rec_valid/rec_ready; the debug bus itself has none.
// master = scanner side, slave = responder + record consumer side.
interface debug_scanner_if;
  logic       e_debug;
  logic [7:0] bus_out;
  logic [7:0] bus_in;
  logic [7:0] bus_oe_in;
  logic       rec_valid;
  logic       rec_ready;
  logic [1:0] rec_kind;
  logic [2:0] rec_row;
  logic [2:0] rec_col;
  logic [2:0] rec_data;

  modport master (
    output e_debug, bus_out, rec_valid, rec_kind, rec_row, rec_col, rec_data,
    input  bus_in, bus_oe_in, rec_ready
  );

  modport slave (
    input  e_debug, bus_out, rec_valid, rec_kind, rec_row, rec_col, rec_data,
    output bus_in, bus_oe_in, rec_ready
  );
endinterface

// File: rtl/debug_scan_addr_gen.sv
// Walks the scan order (board row-major, then current col, then winner) and offers the next command.
// Latency: outputs are combinational from the index registers; adv/clr take effect next edge.
// Backpressure: none; advances only when the FSM pulses adv.
// Ports: clr resets to record 0, adv steps one record; cmd/row/col describe the next record,
// last is high once every record has been issued.
module debug_scan_addr_gen
  import debug_scanner_pkg::*;
#(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       adv,
  output dbg_cmd_e   cmd,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);
  scan_phase_e phase_q;
  logic [2:0]  row_q;
  logic [2:0]  col_q;

  // row/col fall back to 0 when leaving the board phase, so non-board commands carry zero fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_BOARD;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
    end else if (clr) begin
      phase_q <= PH_BOARD;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
    end else if (adv) begin
      case (phase_q)
        PH_BOARD: begin
          if (col_q == 3'(COLS - 1)) begin
            col_q <= 3'd0;
            if (row_q == 3'(ROWS - 1)) begin
              row_q   <= 3'd0;
              phase_q <= PH_COL;
            end else begin
              row_q <= row_q + 3'd1;
            end
          end else begin
            col_q <= col_q + 3'd1;
          end
        end
        PH_COL:  phase_q <= PH_WIN;
        PH_WIN:  phase_q <= PH_END;
        default: phase_q <= PH_END;
      endcase
    end
  end

  always_comb begin
    cmd = CMD_IDLE;
    case (phase_q)
      PH_BOARD: cmd = CMD_READ_BOARD;
      PH_COL:   cmd = CMD_READ_CURRENT_COL;
      PH_WIN:   cmd = CMD_READ_WINNER;
      default:  cmd = CMD_IDLE;
    endcase
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = (phase_q == PH_END);
endmodule

// File: rtl/debug_scanner.sv
// Debug-bus initiator: issues every board/current-col/winner read and streams one record per response.
// Latency: record valid RESP_LAT edges after its command is driven; one ISSUE and one RELEASE cycle overhead.
// Backpressure: rec_valid held with bus_out frozen until rec_ready; no next command until accepted.
// Ports: start/abort control, busy/done/err status, dbg carries bus_out/e_debug/bus_in/bus_oe_in
// toward the responder and rec_* toward the consumer.
module debug_scanner
  import debug_scanner_pkg::*;
#(
  parameter int ROWS     = 6,
  parameter int COLS     = 7,
  parameter int RESP_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic err,
  debug_scanner_if.master dbg
);
  localparam int              LAT_W    = $clog2(RESP_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RESP_LAT - 1);

  scan_state_e      state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [7:0]       bus_out_q, bus_out_d;
  logic             e_debug_q, e_debug_d;
  logic             rec_valid_q, rec_valid_d;
  logic [1:0]       rec_kind_q, rec_kind_d;
  logic [2:0]       rec_row_q, rec_row_d;
  logic [2:0]       rec_col_q, rec_col_d;
  logic [2:0]       rec_data_q, rec_data_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             aborted_q, aborted_d;
  logic             to_release;

  dbg_cmd_e   gen_cmd;
  logic [2:0] gen_row;
  logic [2:0] gen_col;
  logic       gen_last;
  logic       gen_adv;
  logic       gen_clr;
  dbg_bus_t   cur_bus;

  // Low data bits and low enables carry nothing this scanner uses.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{dbg.bus_in[4:0], dbg.bus_oe_in[1:0]};

  assign cur_bus = dbg_bus_t'(bus_out_q);

  debug_scan_addr_gen #(.ROWS(ROWS), .COLS(COLS)) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (gen_clr),
    .adv   (gen_adv),
    .cmd   (gen_cmd),
    .row   (gen_row),
    .col   (gen_col),
    .last  (gen_last)
  );

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    bus_out_d   = bus_out_q;
    e_debug_d   = e_debug_q;
    rec_valid_d = rec_valid_q;
    rec_kind_d  = rec_kind_q;
    rec_row_d   = rec_row_q;
    rec_col_d   = rec_col_q;
    rec_data_d  = rec_data_q;
    err_d       = err_q;
    aborted_d   = aborted_q;
    done_d      = 1'b0;
    gen_adv     = 1'b0;
    gen_clr     = 1'b0;
    to_release  = 1'b0;

    case (state_q)
      IDLE: begin
        bus_out_d = 8'h00;
        e_debug_d = 1'b0;
        if (start) begin
          state_d   = ISSUE;
          bus_out_d = pack_bus(gen_cmd, gen_row, gen_col);
          e_debug_d = 1'b1;
          err_d     = 1'b0;
          aborted_d = 1'b0;
          gen_adv   = 1'b1;
        end
      end
      ISSUE: begin
        if (abort) begin
          to_release = 1'b1;
          aborted_d  = 1'b1;
        end else begin
          state_d = WAIT;
          lat_d   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (abort) begin
          to_release = 1'b1;
          aborted_d  = 1'b1;
        end else begin
          lat_d = lat_q - 1'b1;
          // Counter hits 0 on this edge: exactly RESP_LAT edges after bus_out was loaded.
          if (lat_q == LAT_W'(1)) begin
            state_d     = PRESENT;
            rec_valid_d = 1'b1;
            rec_kind_d  = cur_bus.cmd;
            rec_row_d   = cur_bus.row;
            rec_col_d   = cur_bus.col;
            if (cur_bus.cmd == CMD_READ_CURRENT_COL) rec_data_d = dbg.bus_in[7:5];
            else                                     rec_data_d = {1'b0, dbg.bus_in[7:6]};
            if (dbg.bus_oe_in[7:2] != OE_DATA_ALL) err_d = 1'b1;
          end
        end
      end
      PRESENT: begin
        // Abort wins over a simultaneous handshake: the record is dropped.
        if (abort) begin
          to_release = 1'b1;
          aborted_d  = 1'b1;
        end else if (dbg.rec_ready) begin
          rec_valid_d = 1'b0;
          if (gen_last) begin
            to_release = 1'b1;
          end else begin
            state_d   = ISSUE;
            bus_out_d = pack_bus(gen_cmd, gen_row, gen_col);
            gen_adv   = 1'b1;
          end
        end
      end
      RELEASE: begin
        state_d   = IDLE;
        bus_out_d = 8'h00;
        e_debug_d = 1'b0;
        done_d    = !aborted_q;
        gen_clr   = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // The responder must see cmd 0 with e_debug still high so it drops its enables.
    if (to_release) begin
      state_d     = RELEASE;
      bus_out_d   = 8'h00;
      e_debug_d   = 1'b1;
      rec_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      bus_out_q   <= 8'h00;
      e_debug_q   <= 1'b0;
      rec_valid_q <= 1'b0;
      rec_kind_q  <= 2'd0;
      rec_row_q   <= 3'd0;
      rec_col_q   <= 3'd0;
      rec_data_q  <= 3'd0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      bus_out_q   <= bus_out_d;
      e_debug_q   <= e_debug_d;
      rec_valid_q <= rec_valid_d;
      rec_kind_q  <= rec_kind_d;
      rec_row_q   <= rec_row_d;
      rec_col_q   <= rec_col_d;
      rec_data_q  <= rec_data_d;
      err_q       <= err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      aborted_q   <= aborted_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign dbg.bus_out   = bus_out_q;
  assign dbg.e_debug   = e_debug_q;
  assign dbg.rec_valid = rec_valid_q;
  assign dbg.rec_kind  = rec_kind_q;
  assign dbg.rec_row   = rec_row_q;
  assign dbg.rec_col   = rec_col_q;
  assign dbg.rec_data  = rec_data_q;
endmodule

// File: tb/tb_debug_scanner.sv
// Bench for debug_scanner: default 6x7 instance with RESP_LAT=2 and a 2x2 instance with RESP_LAT=4,
// each talking to a one-register responder model; records are scored against the scan order
// computed directly from row/col arithmetic.
module tb_debug_scanner;
  import debug_scanner_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  debug_scanner_if ifc0 ();
  debug_scanner_if ifc1 ();

  logic start0, abort0, busy0, done0, err0;
  logic start1, abort1, busy1, done1, err1;

  debug_scanner #(.ROWS(6), .COLS(7), .RESP_LAT(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .busy(busy0), .done(done0), .err(err0), .dbg(ifc0)
  );

  debug_scanner #(.ROWS(2), .COLS(2), .RESP_LAT(4)) u_dut_lat4 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .busy(busy1), .done(done1), .err(err1), .dbg(ifc1)
  );

  int   sel = 0;
  logic start_r = 1'b0, abort_r = 1'b0, ready_r = 1'b0;
  bit   fault_on = 1'b0;

  assign start0 = (sel == 0) && start_r;
  assign abort0 = (sel == 0) && abort_r;
  assign ifc0.rec_ready = (sel == 0) && ready_r;
  assign start1 = (sel == 1) && start_r;
  assign abort1 = (sel == 1) && abort_r;
  assign ifc1.rec_ready = (sel == 1) && ready_r;

  logic        o_busy, o_done, o_err, o_e_debug, o_rec_valid;
  logic [7:0]  o_bus_out;
  logic [10:0] o_rec;
  assign o_busy      = (sel == 0) ? busy0 : busy1;
  assign o_done      = (sel == 0) ? done0 : done1;
  assign o_err       = (sel == 0) ? err0 : err1;
  assign o_e_debug   = (sel == 0) ? ifc0.e_debug : ifc1.e_debug;
  assign o_rec_valid = (sel == 0) ? ifc0.rec_valid : ifc1.rec_valid;
  assign o_bus_out   = (sel == 0) ? ifc0.bus_out : ifc1.bus_out;
  assign o_rec = (sel == 0) ? {ifc0.rec_kind, ifc0.rec_row, ifc0.rec_col, ifc0.rec_data}
                            : {ifc1.rec_kind, ifc1.rec_row, ifc1.rec_col, ifc1.rec_data};

  // Responder: board[r][c]=(r+c)%3, current col 5, winner 2; low bits are noise.
  function automatic logic [7:0] resp_data(input logic [7:0] b);
    dbg_bus_t f;
    f = dbg_bus_t'(b);
    case (f.cmd)
      CMD_READ_BOARD:       return {2'((int'(f.row) + int'(f.col)) % 3), 6'($urandom)};
      CMD_READ_CURRENT_COL: return {3'd5, 5'($urandom)};
      CMD_READ_WINNER:      return {2'd2, 6'($urandom)};
      default:              return 8'h00;
    endcase
  endfunction

  // Board cell row 1 col 3 (record 10) is answered with enables off when the fault is armed.
  function automatic logic [7:0] resp_oe(input logic [7:0] b, input bit fault);
    if (b[1:0] == 2'd0) return 8'h00;
    if (fault && b == 8'h2D) return 8'h00;
    return {6'h3F, 2'($urandom)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifc0.bus_in    <= 8'h00;
      ifc0.bus_oe_in <= 8'h00;
    end else if (ifc0.e_debug) begin
      ifc0.bus_in    <= resp_data(ifc0.bus_out);
      ifc0.bus_oe_in <= resp_oe(ifc0.bus_out, fault_on);
    end else begin
      ifc0.bus_oe_in <= 8'h00;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifc1.bus_in    <= 8'h00;
      ifc1.bus_oe_in <= 8'h00;
    end else if (ifc1.e_debug) begin
      ifc1.bus_in    <= resp_data(ifc1.bus_out);
      ifc1.bus_oe_in <= resp_oe(ifc1.bus_out, 1'b0);
    end else begin
      ifc1.bus_oe_in <= 8'h00;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected record i as {kind, row, col, data}.
  function automatic logic [10:0] exp_rec(input int i, input int rows, input int cols);
    int r, c;
    if (i < rows * cols) begin
      r = i / cols;
      c = i % cols;
      return {2'd1, 3'(r), 3'(c), 3'((r + c) % 3)};
    end
    if (i == rows * cols) return {2'd2, 3'd0, 3'd0, 3'd5};
    return {2'd3, 3'd0, 3'd0, 3'd2};
  endfunction

  // ab_mode: 0 none, 1 abort in WAIT of record ab_rec, 2 abort while record ab_rec is presented.
  task automatic run_scan(input int inst, input int rows, input int cols, input int lat,
                          input int pct, input int bp_rec, input int ab_mode, input int ab_rec,
                          input int poke_rec, input bit fault, input bit start_with_abort);
    int         nrec, cyc, since_hs, bp_cnt, t_load, n_exp;
    bit         rdy, ab, pk, ab_prev, prev_valid, prev_ed, exited;
    logic [7:0]  prev_bus;
    logic [19:0] snap;
    sel      = inst;
    fault_on = fault;
    start_r  = 1'b1;
    abort_r  = start_with_abort;
    step();
    start_r = 1'b0;
    abort_r = 1'b0;
    check("start_bus_out", 32'(o_bus_out), 32'h01);
    check("start_e_debug", 32'(o_e_debug), 32'd1);
    check("start_err_clear", 32'(o_err), 32'd0);
    check("start_busy", 32'(o_busy), 32'd1);

    nrec = 0; cyc = 0; since_hs = 100; bp_cnt = 0; t_load = -1; snap = '0;
    ab_prev = 1'b0; exited = 1'b0;
    prev_bus = o_bus_out; prev_valid = o_rec_valid; prev_ed = o_e_debug;
    while (cyc < 5000 && !exited) begin
      if (ab_prev) check("abort_drops_valid", 32'(o_rec_valid), 32'd0);
      if (o_bus_out == 8'h25 && prev_bus != 8'h25) t_load = cyc;
      if (o_rec_valid && !prev_valid && o_bus_out == 8'h25 && t_load >= 0)
        check("resp_latency", 32'(cyc - t_load), 32'(lat));

      rdy = ($urandom_range(0, 99) < pct);
      ab  = 1'b0;
      pk  = 1'b0;
      if (o_rec_valid && nrec == bp_rec && bp_cnt <= 5) begin
        if (bp_cnt == 0) snap = {o_bus_out, o_rec_valid, o_rec};
        else check("backpressure_hold", 32'({o_bus_out, o_rec_valid, o_rec}), 32'(snap));
        if (bp_cnt < 5) rdy = 1'b0;
        bp_cnt++;
      end
      if (ab_mode == 1 && nrec == ab_rec && since_hs == 1 && !o_rec_valid) ab = 1'b1;
      if (ab_mode == 2 && nrec == ab_rec && o_rec_valid) begin
        ab  = 1'b1;
        rdy = 1'b1;
      end
      if (nrec == poke_rec && o_rec_valid) pk = 1'b1;
      ready_r = rdy;
      abort_r = ab;
      start_r = pk;

      if (o_rec_valid && rdy && !ab) begin
        check("record", 32'(o_rec), 32'(exp_rec(nrec, rows, cols)));
        check("err_sticky", 32'(o_err), 32'(fault && nrec >= 10));
        nrec++;
        since_hs = 0;
      end else if (since_hs < 100) begin
        since_hs++;
      end

      ab_prev = ab; prev_bus = o_bus_out; prev_valid = o_rec_valid; prev_ed = o_e_debug;
      step();
      cyc++;
      if (!o_busy) exited = 1'b1;
    end
    ready_r = 1'b0;
    abort_r = 1'b0;
    start_r = 1'b0;
    if (!exited) check("scan_timeout_busy", 32'(o_busy), 32'd0);
    n_exp = (ab_mode != 0) ? ab_rec : rows * cols + 2;
    check("record_count", 32'(nrec), 32'(n_exp));
    check("release_bus_out", 32'(prev_bus), 32'h00);
    check("release_e_debug", 32'(prev_ed), 32'd1);
    check("release_valid", 32'(prev_valid), 32'd0);
    check("idle_e_debug", 32'(o_e_debug), 32'd0);
    check("done_on_idle_entry", 32'(o_done), 32'(ab_mode == 0));
    check("err_at_end", 32'(o_err), 32'(fault));
    step();
    check("done_one_cycle", 32'(o_done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_e_debug", 32'(ifc0.e_debug), 32'd0);
    check("rst_bus_out", 32'(ifc0.bus_out), 32'h00);
    check("rst_rec_valid", 32'(ifc0.rec_valid), 32'd0);
    check("rst_rec_fields", 32'({ifc0.rec_kind, ifc0.rec_row, ifc0.rec_col, ifc0.rec_data}), 32'd0);
    check("rst_lat4_busy", 32'(busy1), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Abort while idle does nothing.
    abort_r = 1'b1;
    step();
    abort_r = 1'b0;
    check("idle_abort_busy", 32'(o_busy), 32'd0);
    check("idle_abort_e_debug", 32'(o_e_debug), 32'd0);

    // Full scan: backpressure on record 3, start poked on record 15, enables dropped on record 10.
    run_scan(0, 6, 7, 2, 100, 3, 0, 0, 15, 1'b1, 1'b0);
    // Random readiness, abort in WAIT of record 20.
    run_scan(0, 6, 7, 2, 60, -1, 1, 20, -1, 1'b0, 1'b0);
    // Fresh scan restarts at record 0; start and abort together in IDLE.
    run_scan(0, 6, 7, 2, 70, 7, 0, 0, -1, 1'b0, 1'b1);
    // Abort while record 5 is presented with rec_ready high.
    run_scan(0, 6, 7, 2, 80, -1, 2, 5, -1, 1'b0, 1'b0);
    // RESP_LAT=4 instance, 2x2 board.
    run_scan(1, 2, 2, 4, 50, 1, 0, 0, 2, 1'b0, 1'b0);

    // Reset in the middle of a scan.
    sel = 0;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_bus_out", 32'(ifc0.bus_out), 32'h00);
    check("midrst_e_debug", 32'(ifc0.e_debug), 32'd0);
    check("midrst_rec_valid", 32'(ifc0.rec_valid), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/debug_scanner.md
Name: debug_scanner

Overview:
- Host-side initiator for the 8-bit debug bus that the game's debug responder serves.
- On `start`, it drives command/address codes onto the bus in order, samples each registered response, and streams a normalized record to a consumer over valid/ready.
- The full scan covers every board cell, then current column, then winner.
- Sits in the test/FPGA harness or a debug bridge, wired to the responder's uio_in (our bus_out) and uio_out/uio_oe (our bus_in/bus_oe_in).

Parameters:
- ROWS, 6, board rows scanned (1..8).
- COLS, 7, board columns scanned (1..8).
- RESP_LAT, 2, edges from bus_out update to valid response sample (>=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a scan; honoured only in IDLE
- abort  in  1  synchronous cancel; returns through RELEASE to IDLE
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when RELEASE completes after a full scan (not after abort)
- err  out  1  sticky; set on bad output-enable at any sample; cleared on accepted start
- e_debug  out  1  debug enable to responder
- bus_out  out  8  [1:0] cmd (0 idle, 1 board, 2 current col, 3 winner), [7:5] row, [4:2] col
- bus_in  in  8  responder data
- bus_oe_in  in  8  responder output enables
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts
- rec_kind  out  2  1 board cell, 2 current col, 3 winner
- rec_row  out  3  row of board record, else 0
- rec_col  out  3  col of board record, else 0
- rec_data  out  3  board: {0,bus_in[7:6]}; col: bus_in[7:5]; winner: {0,bus_in[7:6]}

Behaviour:
- Reset values:
  - state IDLE; all outputs 0.
  - bus_out=8'h00, e_debug=0, rec_* = 0, err=0, internal indices 0.
- All outputs are registered.
- Record sequence: index i=0..ROWS*COLS+1.
  - i<ROWS*COLS: board cell, row=i/COLS, col=i%COLS (row-major, use nested row/col counters, no divider).
  - Then one current-col record, then one winner record. Total ROWS*COLS+2 records (44 at defaults).
- IDLE:
  - e_debug=0, bus_out=0.
  - start -> ISSUE: load bus_out for record 0, e_debug=1, clear err.
- ISSUE (1 cycle): -> WAIT, latency counter = RESP_LAT-1.
- WAIT: decrement each cycle. On the edge where the counter reaches 0:
  - sample bus_in into rec_* and assert rec_valid -> PRESENT.
  - This sample edge is exactly RESP_LAT edges after the bus_out load edge.
- Output-enable check at the sample edge: if bus_oe_in[7:2] != 6'b111111, set err. The record is still presented.
- PRESENT:
  - bus_out and e_debug held.
  - rec_valid and rec_* stable until rec_valid&&rec_ready.
  - On handshake, drop rec_valid the same edge. Then:
    - if last record -> RELEASE;
    - else load next command into bus_out -> ISSUE.
- RELEASE (1 cycle):
  - bus_out=8'h00 with e_debug=1, so the responder latches cmd 0 and drops its enables.
  - Then -> IDLE with e_debug=0; done pulses in the IDLE entry cycle if not aborted.
- abort in ISSUE/WAIT/PRESENT:
  - rec_valid=0 next edge; any pending record is discarded, even if rec_ready is high that cycle.
  - -> RELEASE; no done.
- abort in RELEASE/IDLE: ignored.
- start while busy: ignored.
- start and abort together in IDLE: start wins.
- Reset mid-scan: immediate return to reset values; the responder is not released (it has its own reset).
- Unused bus_out bits for non-board commands (row/col fields) are driven 0.

Decomposition:
- Shared package:
  - cmd codes CMD_IDLE=0, CMD_READ_BOARD=1, CMD_READ_CURRENT_COL=2, CMD_READ_WINNER=3.
  - Bit-field positions of the debug bus.
  - State enum {IDLE, ISSUE, WAIT, PRESENT, RELEASE}.
  - The same command constants must be consumed by the responder.
- One natural sub-module: debug_scan_addr_gen (row/col/phase counters producing next cmd/row/col and a last flag).
- FSM and record register stay in the top.

Test Plan:
- Responder model with board[r][c]=(r+c)%3, current_col=5, winner=2; start, rec_ready=1:
  - 44 records in order, record 0 = (1,0,0,0), record 8 = (1,1,1,2), then (2,0,0,5), (3,0,0,2).
  - done pulses once; busy spans the whole scan.
- Per-record timing: bus_out=8'h25 (row1,col1,cmd1) loaded at edge k; rec_valid rises at edge k+2 with RESP_LAT=2. Repeat with RESP_LAT=4 -> edge k+4.
- Backpressure: hold rec_ready=0 for 5 cycles on record 3 -> rec_valid, rec_*, and bus_out stable, no new command issued; release -> record 4 follows.
- Model drives bus_oe_in=8'h00 on record 10 only -> err=1 and stays 1 through done; next start clears err.
- abort during WAIT of record 20 -> rec_valid stays 0, one RELEASE cycle with bus_out=0 and e_debug=1, then IDLE, no done. A fresh start restarts at record 0.
- start pulsed during PRESENT -> no effect on sequence; count still 44.
